// File: rtl/filter_mac_pkg.sv
// Shared types for the filter MAC: stage-2 window FSM encoding.
package filter_mac_pkg;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/filter_mul.sv
// Registered signed multiplier with a stall enable; carries valid/last tags alongside the product.
module filter_mul #(
    parameter  int A_WIDTH = 16,
    parameter  int B_WIDTH = 16,
    localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      term_val,
    input  logic                      term_last,
    input  logic signed [A_WIDTH-1:0] a,
    input  logic signed [B_WIDTH-1:0] b,
    output logic signed [P_WIDTH-1:0] prod,
    output logic                      prod_val,
    output logic                      prod_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_val  <= 1'b0;
            prod_last <= 1'b0;
        end else if (en) begin
            prod_val  <= term_val;
            prod_last <= term_val & term_last;
        end
    end

    // NOTE: the product register has no reset; prod_val qualifies it, so
    // resetting wide data only costs routing with no functional benefit.
    always_ff @(posedge clk) begin
        if (en && term_val) begin
            prod <= P_WIDTH'(a) * P_WIDTH'(b);
        end
    end

endmodule

// File: rtl/filter_mac.sv
// Streaming multiply-accumulate: sums img*coef over a window delimited by up_last,
// emitting the wrapped sum and a saturating term count through a valid/ready port.
module filter_mac
    import filter_mac_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_WIDTH  = 33,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [IMG_WIDTH-1:0]  up_img,
    input  logic signed [COEF_WIDTH-1:0] up_coef,
    input  logic                         up_last,
    input  logic                         up_val,
    output logic                         up_rdy,
    output logic signed [NUM_WIDTH-1:0]  dn_data,
    output logic [CNT_WIDTH-1:0]         dn_count,
    output logic                         dn_val,
    input  logic                         dn_rdy
);

    localparam int                 PROD_WIDTH = IMG_WIDTH + COEF_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic signed [PROD_WIDTH-1:0] prod;
    logic                         prod_val;
    logic                         prod_last;
    logic signed [NUM_WIDTH-1:0]  prod_ext;

    state_t                       state, state_next;
    logic signed [NUM_WIDTH-1:0]  acc, acc_next;
    logic [CNT_WIDTH-1:0]         cnt, cnt_next;
    logic                         load;

    // A held result freezes both stages, so no term in flight is ever dropped.
    assign up_rdy   = ~dn_val | dn_rdy;
    assign prod_ext = NUM_WIDTH'(prod);

    filter_mul #(
        .A_WIDTH (IMG_WIDTH),
        .B_WIDTH (COEF_WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (up_rdy),
        .term_val  (up_val),
        .term_last (up_last),
        .a         (up_img),
        .b         (up_coef),
        .prod      (prod),
        .prod_val  (prod_val),
        .prod_last (prod_last)
    );

    // NOTE: every output of this block gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        load       = 1'b0;
        if (up_rdy && prod_val) begin
            case (state)
                ST_FIRST: begin
                    acc_next = prod_ext;
                    cnt_next = CNT_WIDTH'(1);
                end
                ST_ACCUM: begin
                    acc_next = acc + prod_ext;
                    cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);
                end
                default: begin
                    acc_next = prod_ext;
                    cnt_next = CNT_WIDTH'(1);
                end
            endcase
            state_next = prod_last ? ST_FIRST : ST_ACCUM;
            load       = prod_last;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FIRST;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
        end
    end

    // A new result may land in the same cycle the old one is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_data  <= '0;
            dn_count <= '0;
            dn_val   <= 1'b0;
        end else if (load) begin
            dn_data  <= acc_next;
            dn_count <= cnt_next;
            dn_val   <= 1'b1;
        end else if (dn_rdy) begin
            dn_val   <= 1'b0;
        end
    end

endmodule

// File: doc/filter_mac.md
FILTER_MAC -- requirements
Module: filter_mac

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 16: signed pixel width.
REQ-002 SHALL have parameter COEF_WIDTH, default 16: signed coefficient width.
REQ-003 SHALL have parameter NUM_WIDTH, default 33: signed accumulator/result width; must be at least IMG_WIDTH+COEF_WIDTH.
REQ-004 SHALL have parameter CNT_WIDTH, default 8: term-counter width.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port up_img, input, IMG_WIDTH: signed pixel term.
REQ-008 SHALL have port up_coef, input, COEF_WIDTH: signed coefficient term.
REQ-009 SHALL have port up_last, input, 1: marks final term of a window.
REQ-010 SHALL have port up_val, input, 1: upstream term valid.
REQ-011 SHALL have port up_rdy, output, 1: block accepts a term this cycle.
REQ-012 SHALL have port dn_data, output, NUM_WIDTH: signed window sum, fed to the rescale stage.
REQ-013 SHALL have port dn_count, output, CNT_WIDTH: number of terms in dn_data's window.
REQ-014 SHALL have port dn_val, output, 1: result valid.
REQ-015 SHALL have port dn_rdy, input, 1: downstream accepts result.

Function
REQ-016 SHALL accept a term when up_val and up_rdy are both high at a clk edge.
REQ-017 SHALL drive up_rdy = ~dn_val | dn_rdy, combinationally; the whole pipeline stalls when dn_val high and dn_rdy low.
REQ-018 SHALL form the full-precision signed product up_img*up_coef in a registered multiply stage (stage 1).
REQ-019 SHALL sign-extend products to NUM_WIDTH and accumulate in stage 2; overflow wraps modulo 2^NUM_WIDTH (no saturation; clamping belongs downstream).
REQ-020 SHALL run a two-state FSM on stage-2 input: FIRST (next product loads the accumulator and the counter is set to 1) and ACCUM (next product is added and the counter increments); FIRST->ACCUM on a non-last product, any state->FIRST on a last product.
REQ-021 SHALL, on the stage-2 product tagged last, load dn_data with the final sum, load dn_count, and set dn_val; latency is 2 cycles from acceptance of the last term to dn_val high, absent stalls.
REQ-022 SHALL treat a window of one term (up_last on the first term) as sum = product, count = 1.
REQ-023 SHALL hold dn_data, dn_count, and dn_val stable while dn_val is high and dn_rdy is low.
REQ-024 SHALL clear dn_val when dn_rdy is high, unless a new result lands in the same cycle, in which case dn_val stays high with the new data (back-to-back throughput of 1 result per cycle for 1-term windows).
REQ-025 SHALL saturate the term counter at 2^CNT_WIDTH-1 and keep accumulating; the sum remains correct.
REQ-026 SHALL let pipeline bubbles (up_val low) advance without altering accumulator or FSM state.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear dn_val, the stage-1 valid and last tags, the accumulator, dn_data, and dn_count to 0, and set the FSM to FIRST.
REQ-028 SHALL discard any partially accumulated window when reset is asserted mid-window; the first term after release starts a new window.
REQ-029 SHALL NOT require a reset on the stage-1 product data register (its valid bit is reset).

Structure
REQ-030 SHALL keep widths as module parameters; product width IMG_WIDTH+COEF_WIDTH and the FSM encodings are localparams; no shared package is required.
REQ-031 SHALL instantiate one sub-module, filter_mul: a registered signed multiplier with an enable (stall) input and a valid/last tag.

Verification
REQ-032 SHALL cover this case: 3-term window (2*3, -4*5, 7*1), dn_rdy=1 -> dn_data=-7, dn_count=3, dn_val high exactly 2 cycles after the last term.
REQ-033 SHALL cover this case: 1-term windows on consecutive cycles (32767*32767, then -32768*-32768) -> dn_data 1073676289 then 1073741824 on consecutive cycles.
REQ-034 SHALL cover this case: dn_rdy held low 5 cycles with a result pending -> up_rdy low, dn_data held, no term lost; sums still correct after release.
REQ-035 SHALL cover this case: 4 terms of (-32768*-32768) -> dn_data = 2^32 in 33-bit signed wrap = -2^32 (0x1_0000_0000); verifies wrap, not saturation.
REQ-036 SHALL cover this case: rst_n pulsed low after 2 of 4 terms -> dn_val=0 immediately; next window 1*1 (last) -> dn_data=1, dn_count=1.
REQ-037 SHALL cover this case: random up_val/dn_rdy gaps over 1000 windows -> results match the reference model in order.
